// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the instruction-memory request/response port and the
//            decode-side instruction port of the fetch unit.
// Ports    : imem_req_*  - request to instruction memory (valid/ready/addr)
//            imem_resp_* - in-order response from memory (valid/ready/data)
//            inst_*      - buffer head towards decode (valid/ready/pc/data)
// Modports : master - the fetch unit; slave - memory + decode environment
// Revision : 1.0 - initial release
//============================================================================
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic            imem_resp_ready;
  logic [XLEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_data;

  modport master (
    output imem_req_valid, imem_req_addr, imem_resp_ready,
           inst_valid, inst_pc, inst_data,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, imem_resp_ready,
           inst_valid, inst_pc, inst_data,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : fetch_unit
// Purpose  : In-order instruction fetch with up to MAX_OUTSTANDING memory
//            requests in flight. Responses are tagged with their PC and
//            queued in an IBUF_DEPTH-entry buffer for decode. A redirect
//            reloads the PC, empties the buffer and drops in-flight returns.
// Ports    : clk, reset_n        - clock, synchronous active-low reset
//            redirect_valid_i/pc - branch/exception redirect
//            bus_io (master)     - memory request/response + decode port
// Revision : 1.0 - initial release
//============================================================================
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              IBUF_DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  fetch_unit_if.master    bus_io
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = $clog2(IBUF_DEPTH + 1);
  localparam int FPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  // active_q is low during reset and the cycle it is released in, so no
  // request or response handshake is offered before state is clean.
  logic            active_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [FPW-1:0]  infl_wr_q, infl_wr_d, infl_rd_q, infl_rd_d;
  logic [BPW-1:0]  ibuf_wr_q, ibuf_wr_d, ibuf_rd_q, ibuf_rd_d;
  logic [CW-1:0]   ibuf_count_q, ibuf_count_d;

  logic [XLEN-1:0] infl_pc_q   [MAX_OUTSTANDING];
  logic [XLEN-1:0] ibuf_pc_q   [IBUF_DEPTH];
  logic [XLEN-1:0] ibuf_data_q [IBUF_DEPTH];

  logic req_valid, req_fire, resp_fire, ibuf_push, ibuf_pop, head_valid;

  function automatic logic [FPW-1:0] infl_next(input logic [FPW-1:0] p);
    return (p == FPW'(MAX_OUTSTANDING - 1)) ? '0 : p + FPW'(1);
  endfunction

  function automatic logic [BPW-1:0] ibuf_next(input logic [BPW-1:0] p);
    return (p == BPW'(IBUF_DEPTH - 1)) ? '0 : p + BPW'(1);
  endfunction

  // Credit counts in-flight requests against buffer space, so every
  // response always has a slot and the response port never stalls.
  assign req_valid  = active_q && !redirect_valid_i
                   && (int'(outstanding_q) < MAX_OUTSTANDING)
                   && ((int'(outstanding_q) + int'(ibuf_count_q)) < IBUF_DEPTH);
  assign req_fire   = req_valid && bus_io.imem_req_ready;
  assign resp_fire  = active_q && bus_io.imem_resp_valid;
  // Responses during a redirect cycle, or while stale ones remain, are dropped.
  assign ibuf_push  = resp_fire && !redirect_valid_i && (drop_q == '0);
  assign head_valid = (ibuf_count_q != '0);
  assign ibuf_pop   = head_valid && bus_io.inst_ready && !redirect_valid_i;

  assign bus_io.imem_req_valid  = req_valid;
  assign bus_io.imem_req_addr   = pc_q;
  assign bus_io.imem_resp_ready = active_q;
  assign bus_io.inst_valid      = head_valid;
  assign bus_io.inst_pc         = head_valid ? ibuf_pc_q[ibuf_rd_q]   : '0;
  assign bus_io.inst_data       = head_valid ? ibuf_data_q[ibuf_rd_q] : '0;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    infl_wr_d     = infl_wr_q;
    infl_rd_d     = infl_rd_q;
    ibuf_wr_d     = ibuf_wr_q;
    ibuf_rd_d     = ibuf_rd_q;
    ibuf_count_d  = ibuf_count_q;

    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (req_fire) begin
      pc_d = pc_q + XLEN'(4);
    end

    unique case ({req_fire, resp_fire})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // The in-flight PC FIFO keeps running through a redirect: dropped
    // responses still pop it so later tags stay aligned.
    if (req_fire)  infl_wr_d = infl_next(infl_wr_q);
    if (resp_fire) infl_rd_d = infl_next(infl_rd_q);

    if (redirect_valid_i) begin
      // A response arriving now is dropped on its own, hence excluded.
      drop_d = outstanding_q - (resp_fire ? OW'(1) : OW'(0));
    end else if (resp_fire && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end

    if (redirect_valid_i) begin
      ibuf_wr_d    = '0;
      ibuf_rd_d    = '0;
      ibuf_count_d = '0;
    end else begin
      if (ibuf_push) ibuf_wr_d = ibuf_next(ibuf_wr_q);
      if (ibuf_pop)  ibuf_rd_d = ibuf_next(ibuf_rd_q);
      unique case ({ibuf_push, ibuf_pop})
        2'b10:   ibuf_count_d = ibuf_count_q + CW'(1);
        2'b01:   ibuf_count_d = ibuf_count_q - CW'(1);
        default: ibuf_count_d = ibuf_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active_q      <= 1'b0;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      infl_wr_q     <= '0;
      infl_rd_q     <= '0;
      ibuf_wr_q     <= '0;
      ibuf_rd_q     <= '0;
      ibuf_count_q  <= '0;
    end else begin
      active_q      <= 1'b1;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      infl_wr_q     <= infl_wr_d;
      infl_rd_q     <= infl_rd_d;
      ibuf_wr_q     <= ibuf_wr_d;
      ibuf_rd_q     <= ibuf_rd_d;
      ibuf_count_q  <= ibuf_count_d;
    end
  end

  // Storage arrays need no reset: contents are only visible behind valid state.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      infl_pc_q[infl_wr_q] <= pc_q;
    end
    if (ibuf_push) begin
      ibuf_pc_q[ibuf_wr_q]   <= infl_pc_q[infl_rd_q];
      ibuf_data_q[ibuf_wr_q] <= bus_io.imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  a_ibuf_bound : assert property (@(posedge clk) disable iff (!reset_n)
    ibuf_count_q <= CW'(IBUF_DEPTH));
  a_resp_has_req : assert property (@(posedge clk) disable iff (!reset_n)
    resp_fire |-> (outstanding_q != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: queue-based reference model
//            checked every cycle, plus directed scenarios with literal pins.
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_unit;
  localparam int          XLEN  = 32;
  localparam int          MAXO  = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int tests  = 0;
  int errors = 0;
  int lat    = 1;
  int mcyc   = 0;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN(XLEN), .MAX_OUTSTANDING(MAXO), .IBUF_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .bus_io           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- memory model: fixed latency, in-order ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) pend.delete();
      else if (bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{addr: bus.imem_req_addr, due: mcyc + lat});
      @(posedge clk);
      #1;
      mcyc++;
      if (pend.size() > 0 && pend[0].due <= mcyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memf(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // In-flight requests carry the redirect epoch they were issued in; a
  // response from an older epoch never reaches the buffer.
  typedef struct { logic [31:0] addr; int epoch; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  infl_t       m_infl[$];
  ent_t        m_buf[$];
  infl_t       m_e;
  logic [31:0] m_pc = RPC;
  int          m_epoch = 0;
  bit          m_active = 0;
  bit          m_reqv;

  initial begin
    forever begin
      @(negedge clk);
      m_reqv = 1'b0;
      if (m_active) begin
        m_reqv = !redirect_valid && (m_infl.size() < MAXO)
              && (m_infl.size() + m_buf.size() < DEPTH);
        chk1("req_valid", bus.imem_req_valid, m_reqv);
        if (m_reqv) chk32("req_addr", bus.imem_req_addr, m_pc);
        chk1("resp_ready", bus.imem_resp_ready, 1'b1);
        chk1("inst_valid", bus.inst_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
          chk32("inst_pc", bus.inst_pc, m_buf[0].pc);
          chk32("inst_data", bus.inst_data, m_buf[0].data);
        end
      end else begin
        chk1("idle_req_valid", bus.imem_req_valid, 1'b0);
        chk1("idle_resp_ready", bus.imem_resp_ready, 1'b0);
        chk1("idle_inst_valid", bus.inst_valid, 1'b0);
      end

      if (!reset_n) begin
        m_active = 0;
        m_infl.delete();
        m_buf.delete();
        m_pc = RPC;
      end else if (!m_active) begin
        m_active = 1;
      end else begin
        if (m_buf.size() != 0 && bus.inst_ready && !redirect_valid)
          void'(m_buf.pop_front());
        if (bus.imem_resp_valid) begin
          if (m_infl.size() == 0) begin
            chk1("resp_without_request", 1'b1, 1'b0);
          end else begin
            m_e = m_infl.pop_front();
            if (m_e.epoch == m_epoch && !redirect_valid)
              m_buf.push_back('{pc: m_e.addr, data: memf(m_e.addr)});
          end
        end
        if (m_reqv && bus.imem_req_ready) begin
          m_infl.push_back('{addr: m_pc, epoch: m_epoch});
          m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) begin
          m_buf.delete();
          m_epoch++;
          m_pc = redirect_pc;
        end
      end
    end
  end

  task automatic do_reset(input int l, input bit rr, input bit ir);
    @(posedge clk);
    #1;
    reset_n            = 1'b0;
    redirect_valid     = 1'b0;
    lat                = l;
    bus.imem_req_ready = rr;
    bus.inst_ready     = ir;
    go(2);
    reset_n = 1'b1;
    go(1);   // now in cycle 1: first cycle the unit is active
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    go(2);
    @(negedge clk);
    chk1 ("rst_req_valid",  bus.imem_req_valid,  1'b0);
    chk1 ("rst_resp_ready", bus.imem_resp_ready, 1'b0);
    chk1 ("rst_inst_valid", bus.inst_valid,      1'b0);
    chk32("rst_inst_pc",    bus.inst_pc,         32'h0);
    chk32("rst_inst_data",  bus.inst_data,       32'h0);
    go(1);
    reset_n = 1'b1;
    go(1);

    // 1-cycle memory, decode always ready
    @(negedge clk); chk1("t1_c1_valid", bus.imem_req_valid, 1'b1);
                    chk32("t1_c1_addr", bus.imem_req_addr, 32'h0);
    go(1);
    @(negedge clk); chk1("t1_c2_inst_valid", bus.inst_valid, 1'b0);
                    chk32("t1_c2_addr", bus.imem_req_addr, 32'h4);
    go(1);
    @(negedge clk); chk1("t1_c3_inst_valid", bus.inst_valid, 1'b1);
                    chk32("t1_c3_inst_pc", bus.inst_pc, 32'h0);
                    chk32("t1_c3_inst_data", bus.inst_data, 32'h5A5A_0F0F);
    go(2);
    @(negedge clk); chk32("t1_c5_inst_pc", bus.inst_pc, 32'h8);
                    chk32("t1_c5_addr", bus.imem_req_addr, 32'h10);

    // memory not ready for 5 cycles (reset applied mid-operation)
    do_reset(1, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); chk1("t2_valid_held", bus.imem_req_valid, 1'b1);
                      chk32("t2_addr_held", bus.imem_req_addr, 32'h0);
      go(1);
    end
    bus.imem_req_ready = 1'b1;
    go(1);
    @(negedge clk); chk32("t2_addr_after", bus.imem_req_addr, 32'h4);

    // 4-cycle memory: outstanding limit of 2
    do_reset(4, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk1("t3_valid", bus.imem_req_valid, (k <= 2) || (k == 6));
      if (k == 6) chk32("t3_c6_addr", bus.imem_req_addr, 32'h8);
      go(1);
    end

    // decode stalled: buffer fills to 4, then fetch resumes at 0x10
    do_reset(1, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk1("t4_valid", bus.imem_req_valid, k <= 4);
      if (k <= 4) chk32("t4_addr", bus.imem_req_addr, 32'(4 * (k - 1)));
      go(1);
    end
    bus.inst_ready = 1'b1;
    @(negedge clk); chk1("t4_c8_valid", bus.imem_req_valid, 1'b0);
                    chk32("t4_c8_inst_pc", bus.inst_pc, 32'h0);
    go(1);
    @(negedge clk); chk1("t4_c9_valid", bus.imem_req_valid, 1'b1);
                    chk32("t4_c9_addr", bus.imem_req_addr, 32'h10);

    // redirect with two requests in flight
    do_reset(4, 1'b1, 1'b1);
    go(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk); chk1("t5_c3_valid", bus.imem_req_valid, 1'b0);
    go(1);
    redirect_valid = 1'b0;
    for (int k = 4; k <= 10; k++) begin
      @(negedge clk);
      chk1("t5_no_stale", bus.inst_valid, 1'b0);
      if (k < 6) chk1("t5_wait_valid", bus.imem_req_valid, 1'b0);
      if (k == 6) chk32("t5_c6_addr", bus.imem_req_addr, 32'h100);
      go(1);
    end
    @(negedge clk); chk1("t5_c11_inst_valid", bus.inst_valid, 1'b1);
                    chk32("t5_c11_inst_pc", bus.inst_pc, 32'h100);

    // redirect coinciding with a response and a decode pop
    do_reset(1, 1'b1, 1'b1);
    go(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk); chk1("t6_c4_valid", bus.imem_req_valid, 1'b0);
                    chk1("t6_c4_resp", bus.imem_resp_valid, 1'b1);
                    chk32("t6_c4_inst_pc", bus.inst_pc, 32'h4);
    go(1);
    redirect_valid = 1'b0;
    @(negedge clk); chk1("t6_c5_inst_valid", bus.inst_valid, 1'b0);
                    chk1("t6_c5_valid", bus.imem_req_valid, 1'b1);
                    chk32("t6_c5_addr", bus.imem_req_addr, 32'h200);
    go(2);
    @(negedge clk); chk32("t6_c7_inst_pc", bus.inst_pc, 32'h200);

    // mixed back-pressure pattern with two redirects, model-checked
    do_reset(2, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      bus.inst_ready     = (i % 3) != 0;
      bus.imem_req_ready = (i % 5) != 2;
      redirect_valid     = (i == 17) || (i == 30);
      redirect_pc        = (i == 17) ? 32'h400 : 32'h800;
      go(1);
    end
    redirect_valid     = 1'b0;
    bus.inst_ready     = 1'b1;
    bus.imem_req_ready = 1'b1;
    go(10);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
